// File: rtl/cpu_idb_arbiter_pkg.sv
// Shared definitions for the CPU-board internal data bus (IDB) arbiter.
//  - idb_state_e : arbiter FSM state encoding
//  - IDB_*       : requester index names (slot in REQ/LOCK/GNT/DATA_IN)
//  - CNT_W       : width of the ownership cycle counter (saturates at all-ones)
//  - TURN_W      : width of the turnaround counter
package cpu_idb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDB_IDLE = 2'd0,
        IDB_OWN  = 2'd1,
        IDB_TURN = 2'd2
    } idb_state_e;

    localparam int unsigned IDB_PROC = 0;
    localparam int unsigned IDB_CS   = 1;
    localparam int unsigned IDB_MMU  = 2;
    localparam int unsigned IDB_EXT  = 3;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TURN_W = 2;

endpackage

// File: rtl/cpu_idb_arbiter_rr_pick.sv
// Round-robin requester selection (purely combinational).
// Searches req starting at ptr+1 (mod N_REQ) and returns the first set index.
//  req   in  N_REQ  request vector
//  ptr   in  PW     index of the last granted requester
//  pick  out PW     selected requester (meaningful only when valid)
//  valid out 1      at least one request is set
module cpu_idb_arbiter_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    pick,
    output logic             valid
);

    logic [2*N_REQ-1:0] req2;
    logic [N_REQ-1:0]   rot;
    int unsigned        off;

    // Rotate so bit 0 is the slot after ptr, priority-encode, then rotate back.
    always_comb begin
        req2 = {req, req};
        rot  = N_REQ'(req2 >> (32'(ptr) + 32'd1));
        off  = 32'd0;
        for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = 32'(j);
            end
        end
        valid = |req;
        pick  = PW'((off + 32'(ptr) + 32'd1) % N_REQ);
    end

endmodule

// File: rtl/cpu_idb_arbiter.sv
// Round-robin sequencer for the CPU-board internal data bus (IDB).
// Grants one requester at a time, inserts a turnaround gap between owners and
// force-releases an owner that holds the bus too long while others wait.
//  sysclk     in   1         clock, all state on rising edge
//  sys_rst_n  in   1         asynchronous active-low reset
//  REQ        in   N_REQ     level requests, held until done
//  LOCK       in   N_REQ     owner's LOCK suppresses the hold timeout
//  DATA_IN    in   N_REQ*DW  requester data, slice i = DATA_IN[i*DW +: DW]
//  ERR_CLR    in   1         clears sticky ERR
//  GNT        out  N_REQ     one-hot grant (registered)
//  IDB_OUT    out  DW        owner's slice, zero when nobody owns the bus
//  BUSY       out  1         bus owned or in turnaround (registered)
//  TIMEOUT    out  1         one-cycle pulse on forced release (registered)
//  ERR        out  1         sticky timeout flag (registered)
module cpu_idb_arbiter
    import cpu_idb_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DW       = 16,
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic                sysclk,
    input  logic                sys_rst_n,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [N_REQ-1:0]    LOCK,
    input  logic [N_REQ*DW-1:0] DATA_IN,
    input  logic                ERR_CLR,
    output logic [N_REQ-1:0]    GNT,
    output logic [DW-1:0]       IDB_OUT,
    output logic                BUSY,
    output logic                TIMEOUT,
    output logic                ERR
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC - 1);

    idb_state_e         state_q, state_n;
    logic [PW-1:0]      owner_q, owner_n;
    logic [PW-1:0]      ptr_q,   ptr_n;
    logic [CNT_W-1:0]   cnt_q,   cnt_n;
    logic [TURN_W-1:0]  turn_q,  turn_n;
    logic [N_REQ-1:0]   gnt_n;
    logic               busy_n, timeout_n, err_n;
    logic               release_c, others_c;
    logic [PW-1:0]      pick;
    logic               pick_valid;

    cpu_idb_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // State and output registers.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDB_IDLE;
            owner_q <= '0;
            ptr_q   <= PW'(N_REQ - 1);
            cnt_q   <= '0;
            turn_q  <= '0;
            GNT     <= '0;
            BUSY    <= 1'b0;
            TIMEOUT <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
            turn_q  <= turn_n;
            GNT     <= gnt_n;
            BUSY    <= busy_n;
            TIMEOUT <= timeout_n;
            ERR     <= err_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        owner_n   = owner_q;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        turn_n    = turn_q;
        gnt_n     = GNT;
        timeout_n = 1'b0;
        err_n     = ERR_CLR ? 1'b0 : ERR;
        release_c = 1'b0;
        // In OWN, GNT is the owner's one-hot, so this is "anyone else waiting".
        others_c  = |(REQ & ~GNT);

        unique case (state_q)
            IDB_IDLE: begin
                if (pick_valid) begin
                    state_n = IDB_OWN;
                    owner_n = pick;
                    ptr_n   = pick;
                    cnt_n   = '0;
                    gnt_n   = N_REQ'(1) << pick;
                end
            end
            IDB_OWN: begin
                cnt_n = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                // A voluntary drop takes precedence over a simultaneous timeout.
                if (!REQ[owner_q]) begin
                    release_c = 1'b1;
                end else if ((cnt_q >= HOLD_LAST) && !LOCK[owner_q] && others_c) begin
                    release_c = 1'b1;
                    timeout_n = 1'b1;
                    err_n     = 1'b1;
                end
                if (release_c) begin
                    gnt_n = '0;
                    if (TURN_CYC > 0) begin
                        state_n = IDB_TURN;
                        turn_n  = '0;
                    end else if (pick_valid) begin
                        // No gap: hand over in the same edge; ptr==owner here so the
                        // releasing requester ranks last.
                        state_n = IDB_OWN;
                        owner_n = pick;
                        ptr_n   = pick;
                        cnt_n   = '0;
                        gnt_n   = N_REQ'(1) << pick;
                    end else begin
                        state_n = IDB_IDLE;
                    end
                end
            end
            IDB_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_n = IDB_IDLE;
                end else begin
                    turn_n = turn_q + TURN_W'(1);
                end
            end
            default: begin
                state_n = IDB_IDLE;
                gnt_n   = '0;
            end
        endcase

        busy_n = (state_n != IDB_IDLE);
    end

    // Bus data: select exactly one slice from the registered grant, else zero.
    always_comb begin
        IDB_OUT = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (GNT[i]) begin
                IDB_OUT = DATA_IN[i*DW +: DW];
            end
        end
    end

    gnt_onehot_a: assert property (@(posedge sysclk) disable iff (!sys_rst_n) $onehot0(GNT));

endmodule

// File: tb/tb_cpu_idb_arbiter.sv
// Self-checking bench for cpu_idb_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of the arbitration rules.
module tb_cpu_idb_arbiter;
    import cpu_idb_arbiter_pkg::*;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned DW       = 16;
    localparam int unsigned HOLD_MAX = 15;
    localparam int unsigned TURN_CYC = 1;

    logic                clk;
    logic                rst_n;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    lock;
    logic [N_REQ*DW-1:0] data;
    logic                err_clr;
    logic [N_REQ-1:0]    gnt;
    logic [DW-1:0]       idb_out;
    logic                busy;
    logic                timeout;
    logic                err;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: who owns the bus, for how long, gap left, last winner.
    int   m_owner;
    int   m_age;
    int   m_wait;
    int   m_last;
    logic m_timeout;
    logic m_err;

    cpu_idb_arbiter #(
        .N_REQ    (N_REQ),
        .DW       (DW),
        .HOLD_MAX (HOLD_MAX),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .sysclk    (clk),
        .sys_rst_n (rst_n),
        .REQ       (req),
        .LOCK      (lock),
        .DATA_IN   (data),
        .ERR_CLR   (err_clr),
        .GNT       (gnt),
        .IDB_OUT   (idb_out),
        .BUSY      (busy),
        .TIMEOUT   (timeout),
        .ERR       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_owner   = -1;
        m_age     = 0;
        m_wait    = 0;
        m_last    = int'(N_REQ) - 1;
        m_timeout = 1'b0;
        m_err     = 1'b0;
    endfunction

    function automatic void model_arbitrate();
        for (int k = 1; k <= int'(N_REQ); k++) begin
            int idx;
            idx = (m_last + k) % int'(N_REQ);
            if (req[idx]) begin
                m_owner = idx;
                m_last  = idx;
                m_age   = 0;
                break;
            end
        end
    endfunction

    function automatic void model_edge();
        logic             tmo;
        logic [N_REQ-1:0] others;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tmo = 1'b0;
        if (m_owner >= 0) begin
            m_age++;
            others = req & ~(N_REQ'(1) << m_owner);
            if (!req[m_owner] ||
                (m_age >= int'(HOLD_MAX) && !lock[m_owner] && others != '0)) begin
                tmo     = req[m_owner];
                m_owner = -1;
                m_wait  = int'(TURN_CYC);
                if (m_wait == 0) model_arbitrate();
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else begin
            model_arbitrate();
        end
        m_timeout = tmo;
        if (tmo) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
    endfunction

    function automatic logic [N_REQ-1:0] exp_gnt();
        return (m_owner >= 0) ? (N_REQ'(1) << m_owner) : '0;
    endfunction

    function automatic logic exp_busy();
        return (m_owner >= 0) || (m_wait > 0);
    endfunction

    function automatic logic [DW-1:0] exp_idb();
        if (m_owner < 0) return '0;
        return data[m_owner*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        lock    = '0;
        err_clr = 1'b0;
        data    = {$urandom, $urandom};
        model_reset();
        step();
        step();
        n_checks++;
        if ({gnt, idb_out} !== '0) begin
            n_fails++;
            $display("FAIL reset_gnt_idb: got gnt=%b idb=%h required 0/0", gnt, idb_out);
        end
        n_checks++;
        if ({busy, timeout, err} !== 3'b000) begin
            n_fails++;
            $display("FAIL reset_flags: got busy/timeout/err=%b required 000", {busy, timeout, err});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_first_grant();
        req  = 4'b0110;
        data = {$urandom, $urandom};
        step();
        n_checks++;
        if (gnt !== N_REQ'(1) << IDB_CS) begin
            n_fails++;
            $display("FAIL first_grant: got %b required 0010", gnt);
        end
        n_checks++;
        if (idb_out !== data[31:16]) begin
            n_fails++;
            $display("FAIL first_grant_idb: got %h required %h", idb_out, data[31:16]);
        end
    endtask

    task automatic test_turnaround();
        req = 4'b0100;
        step();
        n_checks++;
        if ({gnt, busy} !== 5'b0000_1 || idb_out !== '0) begin
            n_fails++;
            $display("FAIL turn_gap: got gnt=%b busy=%b idb=%h required 0000/1/0000", gnt, busy, idb_out);
        end
        step();
        n_checks++;
        if ({gnt, busy} !== 5'b0000_0) begin
            n_fails++;
            $display("FAIL turn_idle: got gnt=%b busy=%b required 0000/0", gnt, busy);
        end
        step();
        n_checks++;
        if (gnt !== N_REQ'(1) << IDB_MMU || idb_out !== data[47:32]) begin
            n_fails++;
            $display("FAIL turn_next_grant: got gnt=%b idb=%h required 0100/%h", gnt, idb_out, data[47:32]);
        end
        req = '0;
        step();
        step();
        n_checks++;
        if (busy !== exp_busy() || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL turn_release_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int waited;
            waited = 0;
            step();
            while (gnt == '0 && waited < 8) begin
                step();
                waited++;
            end
            n_checks++;
            if (gnt !== N_REQ'(1) << (k % 4) || gnt !== exp_gnt()) begin
                n_fails++;
                $display("FAIL rr_order[%0d]: got %b required %b", k, gnt, N_REQ'(1) << (k % 4));
            end
            step();
            req = 4'b1111 & ~gnt;
            step();
            req = 4'b1111;
        end
        req = '0;
        repeat (4) step();
    endtask

    task automatic test_timeout();
        do_reset();
        req  = 4'b1001;
        lock = '0;
        step();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fails++;
            $display("FAIL tmo_grant: got %b required 0001", gnt);
        end
        for (int i = 2; i <= int'(HOLD_MAX); i++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fails++;
                $display("FAIL tmo_hold[%0d]: got gnt=%b timeout=%b required 0001/0", i, gnt, timeout);
            end
        end
        step();
        n_checks++;
        if (timeout !== 1'b1 || err !== 1'b1 || gnt !== '0) begin
            n_fails++;
            $display("FAIL tmo_pulse: got timeout=%b err=%b gnt=%b required 1/1/0000", timeout, err, gnt);
        end
        step();
        n_checks++;
        if (timeout !== 1'b0 || err !== 1'b1) begin
            n_fails++;
            $display("FAIL tmo_after: got timeout=%b err=%b required 0/1", timeout, err);
        end
        step();
        n_checks++;
        if (gnt !== N_REQ'(1) << IDB_EXT) begin
            n_fails++;
            $display("FAIL tmo_handover: got %b required 1000", gnt);
        end
        req = '0;
        repeat (3) step();
    endtask

    task automatic test_lock();
        req     = 4'b1001;
        lock    = 4'b0001;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++;
        if (gnt !== 4'b0001 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL lock_grant_clr: got gnt=%b err=%b required 0001/0", gnt, err);
        end
        for (int i = 2; i <= 20; i++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fails++;
                $display("FAIL lock_hold[%0d]: got gnt=%b timeout=%b required 0001/0", i, gnt, timeout);
            end
        end
        req  = '0;
        lock = '0;
        repeat (3) step();
    endtask

    task automatic test_async_reset();
        req  = 4'b0010;
        data = {$urandom, $urandom};
        step();
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fails++;
            $display("FAIL arst_pre: got %b required 0010", gnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== '0 || idb_out !== '0) begin
            n_fails++;
            $display("FAIL arst_immediate: got gnt=%b idb=%h required 0000/0000", gnt, idb_out);
        end
        model_reset();
        req = 4'b1001;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fails++;
            $display("FAIL arst_first_grant: got %b required 0001", gnt);
        end
        req = '0;
        repeat (3) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < int'(N_REQ); b++) begin
                if ($urandom_range(15) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(31) == 0) lock = ($urandom_range(1) == 0) ? '0 : N_REQ'($urandom);
            err_clr = ($urandom_range(15) == 0);
            data    = {$urandom, $urandom};
            step();
            n_checks++;
            if (gnt !== exp_gnt() || !$onehot0(gnt)) begin
                n_fails++;
                $display("FAIL rand_gnt @%0d: got %b required %b", cyc, gnt, exp_gnt());
            end
            n_checks++;
            if (idb_out !== exp_idb()) begin
                n_fails++;
                $display("FAIL rand_idb @%0d: got %h required %h", cyc, idb_out, exp_idb());
            end
            n_checks++;
            if (busy !== exp_busy()) begin
                n_fails++;
                $display("FAIL rand_busy @%0d: got %b required %b", cyc, busy, exp_busy());
            end
            n_checks++;
            if (timeout !== m_timeout || err !== m_err) begin
                n_fails++;
                $display("FAIL rand_tmo_err @%0d: got %b/%b required %b/%b", cyc, timeout, err, m_timeout, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_turnaround();
        test_round_robin();
        test_timeout();
        test_lock();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
